// File: rtl/varredura_servo_if.sv
// Signal bundle between the sweep sequencer and its servo/sensor neighbours.
// medir is a one-cycle request and medida_pronta its one-cycle ack. The ack is
// honoured only while the sequencer waits for it, and it may arrive at the
// earliest one cycle after medir.
interface varredura_servo_if;
  logic       ligar;
  logic       medida_pronta;
  logic [2:0] posicao;
  logic       medir;
  logic       sentido;
  logic       fim_varredura;
  logic       db_timeout;
  logic [2:0] db_estado;

  modport master (
    input  ligar,
    input  medida_pronta,
    output posicao,
    output medir,
    output sentido,
    output fim_varredura,
    output db_timeout,
    output db_estado
  );

  modport slave (
    output ligar,
    output medida_pronta,
    input  posicao,
    input  medir,
    input  sentido,
    input  fim_varredura,
    input  db_timeout,
    input  db_estado
  );
endinterface

// File: rtl/varredura_servo.sv
// Ping-pong sweep sequencer (0..7..0) that settles, triggers a measurement and waits for the ack.
// Optional feature: define TIMEOUT_MEDIDA_EN to bound the wait for medida_pronta by TIMEOUT cycles.
module varredura_servo #(
  parameter int unsigned ESPERA  = 50000000,
  parameter int unsigned TIMEOUT = 5000000
) (
  input logic               clock,
  input logic               reset,
  varredura_servo_if.master bus
);

  typedef enum logic [2:0] {
    S_INICIAL = 3'd0,
    S_ESPERA  = 3'd1,
    S_MEDIR   = 3'd2,
    S_AGUARDA = 3'd3,
    S_PROXIMA = 3'd4
  } estado_t;

  localparam int unsigned CW = $clog2(ESPERA + 1);
  localparam logic [CW-1:0] ESPERA_ULT = CW'(ESPERA - 1);

`ifdef TIMEOUT_MEDIDA_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_ULT = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt, tcnt_next;
  logic          timeout_q, timeout_next;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  estado_t       state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    posicao, posicao_next;
  logic          sentido, sentido_next;
  logic          medir_q, medir_next;
  logic          fim_q, fim_next;
  logic          avanca;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_INICIAL;
      cnt     <= '0;
      posicao <= 3'd0;
      sentido <= 1'b0;
      medir_q <= 1'b0;
      fim_q   <= 1'b0;
`ifdef TIMEOUT_MEDIDA_EN
      tcnt      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      posicao <= posicao_next;
      sentido <= sentido_next;
      medir_q <= medir_next;
      fim_q   <= fim_next;
`ifdef TIMEOUT_MEDIDA_EN
      tcnt      <= tcnt_next;
      timeout_q <= timeout_next;
`endif
    end
  end

  // Pulses are computed for the state being entered, so each one is
  // registered and lines up with the cycle that state is occupied.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    posicao_next = posicao;
    sentido_next = sentido;
    medir_next   = 1'b0;
    fim_next     = 1'b0;
    avanca       = 1'b0;
`ifdef TIMEOUT_MEDIDA_EN
    tcnt_next    = tcnt;
    timeout_next = 1'b0;
`endif
    if (!bus.ligar) begin
      state_next = S_INICIAL;
    end else begin
      case (state)
        S_INICIAL: begin
          state_next   = S_ESPERA;
          posicao_next = 3'd0;
          sentido_next = 1'b0;
          cnt_next     = '0;
        end
        S_ESPERA: begin
          if (cnt == ESPERA_ULT) begin
            state_next = S_MEDIR;
            medir_next = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        S_MEDIR: begin
          state_next = S_AGUARDA;
`ifdef TIMEOUT_MEDIDA_EN
          tcnt_next  = '0;
`endif
        end
        S_AGUARDA: begin
`ifdef TIMEOUT_MEDIDA_EN
          // An ack on the last allowed cycle is a normal completion.
          if (bus.medida_pronta || (tcnt == TIMEOUT_ULT)) begin
            avanca       = 1'b1;
            timeout_next = !bus.medida_pronta;
          end else begin
            tcnt_next = tcnt + TW'(1);
          end
`else
          if (bus.medida_pronta) avanca = 1'b1;
`endif
        end
        S_PROXIMA: begin
          state_next = S_ESPERA;
          cnt_next   = '0;
        end
        default: state_next = S_INICIAL;
      endcase

      // The new position is committed on entry to PROXIMA, so the settle
      // time starts counting from the cycle posicao actually changes.
      if (avanca) begin
        state_next = S_PROXIMA;
        if (!sentido) begin
          if (posicao != 3'd7) begin
            posicao_next = posicao + 3'd1;
          end else begin
            sentido_next = 1'b1;
            posicao_next = 3'd6;
          end
        end else begin
          if (posicao != 3'd0) begin
            posicao_next = posicao - 3'd1;
          end else begin
            sentido_next = 1'b0;
            posicao_next = 3'd1;
            fim_next     = 1'b1;
          end
        end
      end
    end
  end

  assign bus.posicao       = posicao;
  assign bus.sentido       = sentido;
  assign bus.medir         = medir_q;
  assign bus.fim_varredura = fim_q;
  assign bus.db_estado     = state;
`ifdef TIMEOUT_MEDIDA_EN
  assign bus.db_timeout    = timeout_q;
`else
  assign bus.db_timeout    = 1'b0;
`endif

endmodule
